// File: rtl/synth_frame_sequencer.sv
// Frames the MCU byte stream (sync, payload, sum) for the synth config control unit.
// Forwards payload bytes and commits only complete, checksum-valid frames.
module synth_frame_sequencer #(
  parameter int              WIDTH       = 8,
  parameter int              FRAME_BYTES = 64,
  parameter logic [WIDTH-1:0] SYNC       = 8'hA5,
  parameter int              TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_byte,
  input  logic             rx_valid,
  input  logic             rx_cs_n,
  output logic [WIDTH-1:0] cu_sig_in,
  output logic             cu_enable,
  output logic             cu_frame_start,
  output logic             commit,
  output logic             busy,
  output logic [15:0]      frame_ok_cnt,
  output logic [15:0]      frame_err_cnt,
  output logic [2:0]       last_err
);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_PAYLOAD, S_CHECK, S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             en_q, en_d;
  logic             fs_q, fs_d;
  logic             commit_q, commit_d;
  logic             busy_q, busy_d;
  logic [15:0]      ok_cnt_q, ok_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [2:0]       lerr_q, lerr_d;
  logic             acc, tmo, ok_ev, err_ev;

  assign acc = rx_valid & ~rx_cs_n;
  assign tmo = (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    data_d   = data_q;
    lerr_d   = lerr_q;
    en_d     = 1'b0;
    fs_d     = 1'b0;
    commit_d = 1'b0;
    ok_ev    = 1'b0;
    err_ev   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (acc) begin
          if (rx_byte == SYNC) begin
            state_d = S_PAYLOAD;
            fs_d    = 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DRAIN;
            lerr_d  = 3'd1;
            err_ev  = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        // chip-select release beats a coincident byte and the timer
        if (rx_cs_n) begin
          state_d = S_IDLE;
          lerr_d  = 3'd4;
          err_ev  = 1'b1;
        end else if (rx_valid) begin
          data_d = rx_byte;
          en_d   = 1'b1;
          sum_d  = sum_q + rx_byte;
          cnt_d  = cnt_q + CW'(1);
          tmr_d  = '0;
          if (cnt_q == CW'(FRAME_BYTES - 1)) state_d = S_CHECK;
        end else if (tmo) begin
          state_d = S_DRAIN;
          lerr_d  = 3'd3;
          err_ev  = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (rx_cs_n) begin
          state_d = S_IDLE;
          lerr_d  = 3'd4;
          err_ev  = 1'b1;
        end else if (rx_valid) begin
          tmr_d   = '0;
          state_d = S_DRAIN;
          if (rx_byte == sum_q) begin
            commit_d = 1'b1;
            ok_ev    = 1'b1;
            lerr_d   = 3'd0;
          end else begin
            lerr_d = 3'd2;
            err_ev = 1'b1;
          end
        end else if (tmo) begin
          state_d = S_DRAIN;
          lerr_d  = 3'd3;
          err_ev  = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (rx_cs_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d == S_PAYLOAD) || (state_d == S_CHECK);
    ok_cnt_d  = (ok_ev && ok_cnt_q != 16'hFFFF) ? ok_cnt_q + 16'd1 : ok_cnt_q;
    err_cnt_d = (err_ev && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      fs_q      <= 1'b0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
      lerr_q    <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      data_q    <= data_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
      commit_q  <= commit_d;
      busy_q    <= busy_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
      lerr_q    <= lerr_d;
    end
  end

  assign cu_sig_in      = data_q;
  assign cu_enable      = en_q;
  assign cu_frame_start = fs_q;
  assign commit         = commit_q;
  assign busy           = busy_q;
  assign frame_ok_cnt   = ok_cnt_q;
  assign frame_err_cnt  = err_cnt_q;
  assign last_err       = lerr_q;
endmodule

// File: tb/tb_synth_frame_sequencer.sv
// Bench for synth_frame_sequencer: frame vector table, forwarded-byte scoreboard,
// plus timeout, reset and saturation sequences.
module tb_synth_frame_sequencer;
  localparam int         FB   = 4;
  localparam int         TMO  = 32;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 0, rst = 1;
  logic [7:0]  rx_byte = 0;
  logic        rx_valid = 0, rx_cs_n = 1;
  logic [7:0]  cu_sig_in;
  logic        cu_enable, cu_frame_start, commit, busy;
  logic [15:0] frame_ok_cnt, frame_err_cnt;
  logic [2:0]  last_err;

  synth_frame_sequencer #(.WIDTH(8), .FRAME_BYTES(FB), .SYNC(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_cs_n(rx_cs_n),
    .cu_sig_in(cu_sig_in), .cu_enable(cu_enable), .cu_frame_start(cu_frame_start),
    .commit(commit), .busy(busy), .frame_ok_cnt(frame_ok_cnt),
    .frame_err_cnt(frame_err_cnt), .last_err(last_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int n_commit = 0, n_fs = 0;
  logic prev_commit = 0;
  logic [7:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cu_enable) begin
        if (q.size() == 0) check("fwd_unexpected", {24'd0, cu_sig_in}, 32'hFFFF_FFFF);
        else check("fwd_byte", {24'd0, cu_sig_in}, {24'd0, q.pop_front()});
      end
      if (commit) n_commit++;
      if (cu_frame_start) n_fs++;
      if (commit && prev_commit) check("commit_double", 1, 0);
      prev_commit = commit;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic cs_set(input logic v);
    @(posedge clk); #1;
    rx_cs_n = v;
  endtask

  task automatic run_frame(input logic [63:0] by, input int n, input int gap);
    logic [7:0] b;
    cs_set(0);
    for (int i = 0; i < n; i++) begin
      b = by[63-8*i -: 8];
      if (by[63:56] == SYNC && i >= 1 && i <= FB) q.push_back(b);
      send_byte(b);
      if (i == 0) begin
        @(negedge clk);
        check("busy_after_first", {31'd0, busy}, {31'd0, by[63:56] == SYNC});
      end
      repeat (gap) @(posedge clk);
    end
    cs_set(1);
    send_byte(SYNC);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] by;
    int          n;
    int          commit;
    logic [2:0]  err;
    int          ok;
    int          errc;
    int          fs;
  } vec_t;

  vec_t vt[7];
  int c0, f0, ec;

  initial begin
    vt[0] = '{64'hA5_01_02_03_04_0A_00_00, 6, 1, 3'd0, 1, 0, 1};
    vt[1] = '{64'hA5_01_02_03_04_0B_00_00, 6, 0, 3'd2, 1, 1, 1};
    vt[2] = '{64'h5A_01_02_03_04_0A_00_00, 6, 0, 3'd1, 1, 2, 0};
    vt[3] = '{64'hA5_10_20_30_40_A0_00_00, 6, 1, 3'd0, 2, 2, 1};
    vt[4] = '{64'hA5_01_02_00_00_00_00_00, 3, 0, 3'd4, 2, 3, 1};
    vt[5] = '{64'hA5_FF_FF_FF_FF_FC_00_00, 6, 1, 3'd0, 3, 3, 1};
    vt[6] = '{64'hA5_01_02_03_04_0A_77_00, 7, 1, 3'd0, 4, 3, 1};

    #12;
    check("reset_outputs",
          {cu_sig_in, cu_enable, cu_frame_start, commit, busy, last_err},
          32'd0);
    check("reset_counters", {frame_ok_cnt, frame_err_cnt}, 32'd0);
    @(posedge clk); #1 rst = 0;

    for (int k = 0; k < 7; k++) begin
      c0 = n_commit; f0 = n_fs;
      run_frame(vt[k].by, vt[k].n, 0);
      check($sformatf("v%0d_commit", k), n_commit - c0, vt[k].commit);
      check($sformatf("v%0d_fstart", k), n_fs - f0, vt[k].fs);
      check($sformatf("v%0d_last_err", k), {29'd0, last_err}, {29'd0, vt[k].err});
      check($sformatf("v%0d_ok_cnt", k), {16'd0, frame_ok_cnt}, vt[k].ok);
      check($sformatf("v%0d_err_cnt", k), {16'd0, frame_err_cnt}, vt[k].errc);
      check($sformatf("v%0d_fwd_left", k), q.size(), 0);
      check($sformatf("v%0d_busy_end", k), {31'd0, busy}, 0);
    end

    c0 = n_commit;
    run_frame(64'hA5_01_02_03_04_0A_00_00, 6, TMO - 6);
    check("gap_commit", n_commit - c0, 1);
    check("gap_err_cnt", {16'd0, frame_err_cnt}, 3);
    check("gap_last_err", {29'd0, last_err}, 0);

    c0 = n_commit; ec = frame_err_cnt;
    cs_set(0);
    send_byte(SYNC);
    q.push_back(8'h01);
    send_byte(8'h01);
    repeat (TMO + 4) @(posedge clk);
    @(negedge clk);
    check("tmo_last_err", {29'd0, last_err}, 3);
    check("tmo_err_cnt", {16'd0, frame_err_cnt}, ec + 1);
    check("tmo_busy", {31'd0, busy}, 0);
    send_byte(8'h02);
    cs_set(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tmo_commit", n_commit - c0, 0);
    check("tmo_err_once", {16'd0, frame_err_cnt}, ec + 1);
    check("tmo_fwd_left", q.size(), 0);

    c0 = n_commit;
    run_frame(64'hA5_01_02_03_04_0A_00_00, 6, 0);
    check("post_tmo_commit", n_commit - c0, 1);

    c0 = n_commit;
    cs_set(0);
    send_byte(SYNC);
    q.push_back(8'h01);
    send_byte(8'h01);
    @(negedge clk); #1;
    rst = 1;
    #1;
    check("rst_async_outputs",
          {cu_sig_in, cu_enable, cu_frame_start, commit, busy, last_err},
          32'd0);
    check("rst_async_counters", {frame_ok_cnt, frame_err_cnt}, 32'd0);
    q.delete();
    rx_cs_n = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_commit", n_commit - c0, 0);

    force dut.ok_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.ok_cnt_q;
    c0 = n_commit;
    run_frame(64'hA5_01_02_03_04_0A_00_00, 6, 0);
    check("sat_commit", n_commit - c0, 1);
    check("sat_ok_cnt", {16'd0, frame_ok_cnt}, 32'h0000_FFFF);
    check("sat_last_err", {29'd0, last_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
